// File: rtl/uart_tx_packer.sv
// Word-to-byte packer feeding the UART transmitter.
// Words from the bus side go into a small FIFO. Each word is split into bytes,
// least significant byte first. Bytes are handed to the UART through a level
// handshake (tx_en / tx_busy).
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | nothing in flight; start when the FIFO has a word and UART is free
//   LOAD  | pop the head word into the shift register
//   SEND  | tx_en high with tx_data stable until the UART reports busy
//   WAIT  | UART transmitting; on completion go to the next byte or to IDLE
module uart_tx_packer #(
  parameter int WORD_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_en,
  input  logic                  tx_busy,
  output logic                  idle
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int NB    = WORD_WIDTH / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    WAIT = 2'd3
  } state_t;

  state_t                  state;
  logic [WORD_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count;
  logic [WORD_WIDTH-1:0]   sh;
  logic [WORD_WIDTH-1:0]   sh_next;
  logic [WORD_WIDTH-1:0]   head;
  logic [IDX_W-1:0]        byte_idx;
  logic                    push;
  logic                    pop;
  logic                    last_byte;

  assign word_ready = (count != CNT_W'(FIFO_DEPTH));
  assign push       = word_valid && word_ready;
  // LOAD is only entered with a non-empty FIFO, so the pop never underflows.
  assign pop        = (state == LOAD);
  assign idle       = (count == '0) && (state == IDLE);
  assign head       = mem[rd_ptr];
  assign sh_next    = sh >> 8;
  assign last_byte  = (byte_idx == IDX_W'(NB - 1));

  // FIFO storage: written on an accepted push, no reset needed for the data.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= word_in;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sequencer: tx_data/tx_en are loaded on the transition into SEND so the
  // UART always sees a byte that is stable for the whole request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      sh       <= '0;
      byte_idx <= '0;
      tx_data  <= 8'h00;
      tx_en    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx_en <= 1'b0;
          // A frame left over from before a packer reset keeps tx_busy high.
          if ((count != '0) && !tx_busy) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          sh       <= head;
          byte_idx <= '0;
          tx_data  <= head[7:0];
          tx_en    <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (tx_busy) begin
            tx_en <= 1'b0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!tx_busy) begin
            if (last_byte) begin
              state <= IDLE;
            end else begin
              sh       <= sh_next;
              byte_idx <= byte_idx + IDX_W'(1);
              tx_data  <= sh_next[7:0];
              tx_en    <= 1'b1;
              state    <= SEND;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_packer.sv
// Self-checking bench for uart_tx_packer with a simple UART model.
module tb_uart_tx_packer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] word_in = '0;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        tx_busy;
  logic        idle;

  int tests = 0;
  int fails = 0;

  // UART model control
  logic uart_auto = 1'b0;
  logic man_busy  = 1'b0;
  int   busy_len  = 10;
  logic model_busy = 1'b0;
  int   busy_cnt  = 0;
  logic tx_en_q   = 1'b0;
  int   rise_cnt  = 0;
  logic [7:0] rx_q [$];

  assign tx_busy = uart_auto ? model_busy : man_busy;

  uart_tx_packer #(.WORD_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .tx_data    (tx_data),
    .tx_en      (tx_en),
    .tx_busy    (tx_busy),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  // UART model: latches a byte when tx_en is seen while free, then busy for busy_len clk.
  always @(posedge clk) begin
    tx_en_q <= tx_en;
    if (tx_en && !tx_en_q) rise_cnt <= rise_cnt + 1;
    if (!uart_auto) begin
      model_busy <= 1'b0;
      busy_cnt   <= 0;
    end else if (model_busy) begin
      if (busy_cnt == 0) model_busy <= 1'b0;
      else busy_cnt <= busy_cnt - 1;
    end else if (tx_en) begin
      rx_q.push_back(tx_data);
      model_busy <= 1'b1;
      busy_cnt   <= busy_len - 1;
    end
  end

  typedef struct {
    logic [31:0] word;
    int          blen;
    logic [7:0]  exp [4];
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    word_valid = 1'b0;
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic push(input logic [31:0] w);
    word_in = w;
    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
  endtask

  task automatic wait_rx(input string name, input int n, input int budget);
    int c = 0;
    while (rx_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    check(name, rx_q.size(), n);
  endtask

  task automatic check_words(input string name, input int base, input logic [31:0] ws [$]);
    int nbytes = ws.size() * 4;
    logic [7:0] b;
    int bad = 0;
    for (int i = 0; i < nbytes; i++) begin
      b = 8'((ws[i/4] >> (8 * (i % 4))) & 32'hFF);
      if (base + i >= rx_q.size() || rx_q[base + i] !== b) bad++;
    end
    check(name, bad, 0);
  endtask

  initial begin
    logic [31:0] ws [$];
    int base;
    int rbase;
    logic [7:0] d;
    bit stable;

    vecs[0].word = 32'hA1B2C3D4; vecs[0].blen = 10; vecs[0].exp = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    vecs[1].word = 32'h00000000; vecs[1].blen = 1;  vecs[1].exp = '{8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2].word = 32'hFFFFFFFF; vecs[2].blen = 3;  vecs[2].exp = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    vecs[3].word = 32'h80010F7E; vecs[3].blen = 5;  vecs[3].exp = '{8'h7E, 8'h0F, 8'h01, 8'h80};

    // reset state
    uart_auto = 1'b0;
    man_busy  = 1'b0;
    rstn = 1'b0;
    #2;
    check("rst_tx_en", tx_en, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_ready", word_ready, 1);
    check("rst_idle", idle, 1);
    do_reset();

    // table-driven single words
    uart_auto = 1'b1;
    for (int v = 0; v < 4; v++) begin
      busy_len = vecs[v].blen;
      base  = rx_q.size();
      rbase = rise_cnt;
      push(vecs[v].word);
      wait_rx($sformatf("vec%0d_count", v), base + 4, 500);
      for (int k = 0; k < 4; k++) begin
        if (base + k < rx_q.size()) check($sformatf("vec%0d_byte%0d", v, k), rx_q[base + k], vecs[v].exp[k]);
        else check($sformatf("vec%0d_byte%0d", v, k), 32'hDEAD, vecs[v].exp[k]);
      end
      repeat (vecs[v].blen + 5) tick();
      check($sformatf("vec%0d_rises", v), rise_cnt - rbase, 4);
      check($sformatf("vec%0d_idle", v), idle, 1);
      check($sformatf("vec%0d_extra", v), rx_q.size(), base + 4);
    end

    // full FIFO with tx_busy stuck high
    uart_auto = 1'b0;
    man_busy  = 1'b1;
    do_reset();
    ws = {32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("full_ready_pre%0d", i), word_ready, 1);
      push(ws[i]);
    end
    check("full_ready_after4", word_ready, 0);
    push(32'hBAD0BAD0);
    check("full_ready_after5", word_ready, 0);
    check("full_idle", idle, 0);
    busy_len = 2;
    base = rx_q.size();
    uart_auto = 1'b1;
    wait_rx("full_count", base + 16, 2000);
    repeat (20) tick();
    check("full_no_extra", rx_q.size(), base + 16);
    check_words("full_order", base, ws);
    check("full_idle_end", idle, 1);

    // push on the LOAD cycle with a full FIFO: ignored
    uart_auto = 1'b0;
    man_busy  = 1'b1;
    do_reset();
    ws = {32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
    for (int i = 0; i < 4; i++) push(ws[i]);
    man_busy = 1'b0;
    tick();
    word_in = 32'hBAD1BAD1;
    word_valid = 1'b1;
    check("load_full_ready", word_ready, 0);
    tick();
    word_valid = 1'b0;
    check("load_full_count", dut.count, 3);
    check("load_full_tx_en", tx_en, 1);
    base = rx_q.size();
    uart_auto = 1'b1;
    wait_rx("load_full_bytes", base + 16, 2000);
    repeat (20) tick();
    check("load_full_no_extra", rx_q.size(), base + 16);
    check_words("load_full_order", base, ws);

    // push on the LOAD cycle with count=2: count unchanged
    uart_auto = 1'b0;
    man_busy  = 1'b1;
    do_reset();
    ws = {32'hCAFEF00D, 32'h12345678, 32'h87654321};
    push(ws[0]);
    push(ws[1]);
    man_busy = 1'b0;
    tick();
    word_in = ws[2];
    word_valid = 1'b1;
    check("load_two_ready", word_ready, 1);
    tick();
    word_valid = 1'b0;
    check("load_two_count", dut.count, 2);
    base = rx_q.size();
    uart_auto = 1'b1;
    wait_rx("load_two_bytes", base + 12, 2000);
    repeat (20) tick();
    check("load_two_no_extra", rx_q.size(), base + 12);
    check_words("load_two_order", base, ws);

    // start guard: busy at reset release, FIFO loaded
    uart_auto = 1'b0;
    man_busy  = 1'b1;
    do_reset();
    push(32'h5A6B7C8D);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (tx_en !== 1'b0 || idle !== 1'b0) stable = 1'b0;
    end
    check("guard_hold", stable, 1);
    man_busy = 1'b0;
    tick();
    check("guard_load_tx_en", tx_en, 0);
    tick();
    check("guard_send_tx_en", tx_en, 1);

    // handshake: request held for 50 clk while UART stays free
    d = tx_data;
    check("hs_first_byte", d, 8'h8D);
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (tx_en !== 1'b1 || tx_data !== d) stable = 1'b0;
    end
    check("hs_stable50", stable, 1);
    man_busy = 1'b1;
    tick();
    check("hs_drop_tx_en", tx_en, 0);
    tick();
    check("hs_wait_tx_en", tx_en, 0);
    man_busy = 1'b0;
    tick();
    check("hs_next_tx_en", tx_en, 1);
    check("hs_next_byte", tx_data, 8'h7C);

    // asynchronous reset mid-SEND
    #2;
    rstn = 1'b0;
    #1;
    check("async_tx_en", tx_en, 0);
    check("async_tx_data", tx_data, 0);
    check("async_ready", word_ready, 1);
    check("async_idle", idle, 1);
    tick();
    rstn = 1'b1;
    tick();

    // randomized traffic against a word-queue reference
    uart_auto = 1'b1;
    busy_len = 3;
    ws = {};
    base = rx_q.size();
    for (int c = 0; c < 400; c++) begin
      if (c % 100 == 0) busy_len = int'($urandom_range(1, 6));
      word_in = $urandom;
      word_valid = ($urandom_range(0, 3) == 0);
      if (word_valid && word_ready) ws.push_back(word_in);
      tick();
    end
    word_valid = 1'b0;
    wait_rx("rand_count", base + ws.size() * 4, 20000);
    repeat (20) tick();
    check("rand_no_extra", rx_q.size(), base + ws.size() * 4);
    check_words("rand_order", base, ws);
    check("rand_idle", idle, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
